// File: rtl/imem_fetch_sequencer_if.sv
// Bus bundle around imem_fetch_sequencer.
// Groups the loader write port, the instruction-memory port and the decode
// handshake. The master modport is the sequencer's view. The slave modport is
// the view of the surrounding memory, loader and decode logic.
//   ld_req/ld_addr/ld_data -> ld_gnt         : loader write request / grant
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata : single-port memory
//   instr/instr_pc/instr_valid <- stall/redirect/redirect_pc : decode handshake
interface imem_fetch_sequencer_if #(
    parameter int AW = 13
);
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_gnt;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;

    modport master (
        input  ld_req, ld_addr, ld_data, mem_rdata, stall, redirect, redirect_pc,
        output ld_gnt, mem_en, mem_we, mem_addr, mem_wdata, instr, instr_pc, instr_valid
    );

    modport slave (
        output ld_req, ld_addr, ld_data, mem_rdata, stall, redirect, redirect_pc,
        input  ld_gnt, mem_en, mem_we, mem_addr, mem_wdata, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Instruction-memory fetch sequencer.
// This block generates the PC and issues synchronous reads to a single-port
// instruction memory. It presents the fetched words to decode with a
// valid/stall handshake. A program loader shares the same memory port. The
// loader always has priority, and a write suppresses that cycle's read.
// Ports:
//   clk, rst_n : clock; asynchronous active-low reset
//   start      : pulse; IDLE/HALT -> FETCH, PC restarts at RESET_PC
//   halted     : registered; high while halted on HALT_WORD
//   bus        : loader, memory and decode signals (master modport)
module imem_fetch_sequencer #(
    parameter int          AW        = 13,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [31:0] HALT_WORD = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic halted,
    imem_fetch_sequencer_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic [AW-1:0] ipc;
    logic          rd_pending;

    logic          in_fetch;
    logic          redir;
    logic          valid;
    logic          accept;
    logic          halt_acc;
    logic          issue;
    logic [AW-1:0] issue_addr;

    always_comb begin
        in_fetch   = (state == ST_FETCH);
        redir      = in_fetch & bus.redirect;
        // A redirect drops the word that is in flight.
        valid      = rd_pending & ~redir;
        accept     = valid & ~bus.stall;
        halt_acc   = accept & (bus.mem_rdata == HALT_WORD);
        // Issue a read when the port is free and the output slot is empty or
        // is being consumed. A redirect always refetches.
        issue      = in_fetch & ~bus.ld_req & ~halt_acc & (redir | ~rd_pending | accept);
        issue_addr = redir ? bus.redirect_pc : pc;

        bus.ld_gnt    = bus.ld_req;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.ld_req) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_data;
        end else if (issue) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = issue_addr;
        end
    end

    // Memory read data is held by the RAM while no read is issued. This keeps
    // a stalled instruction on the output without a local copy.
    assign bus.instr       = bus.mem_rdata;
    assign bus.instr_pc    = ipc;
    assign bus.instr_valid = valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            ipc        <= '0;
            rd_pending <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state      <= ST_FETCH;
                        pc         <= RESET_PC;
                        rd_pending <= 1'b0;
                        halted     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (halt_acc) begin
                        state      <= ST_HALT;
                        halted     <= 1'b1;
                        rd_pending <= 1'b0;
                    end else if (issue) begin
                        ipc        <= issue_addr;
                        pc         <= issue_addr + AW'(1);
                        rd_pending <= 1'b1;
                    end else if (redir) begin
                        // The loader took the port. Remember the target and
                        // fetch from it next cycle.
                        pc         <= bus.redirect_pc;
                        rd_pending <= 1'b0;
                    end else if (accept) begin
                        rd_pending <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    rd_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
module tb_imem_fetch_sequencer;
    localparam int          AW   = 13;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic halted;

    imem_fetch_sequencer_if #(.AW(AW)) bus();

    imem_fetch_sequencer #(
        .AW(AW),
        .RESET_PC(13'd0),
        .HALT_WORD(HALT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .halted(halted),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM. The read data holds when no read is issued.
    logic [31:0] mem  [0:8191];
    logic [31:0] gold [0:8191];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, bus.instr_valid, 0);
        chk({tag, "_en"},    bus.mem_en, 0);
        chk({tag, "_we"},    bus.mem_we, 0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_gnt"},   bus.ld_gnt, 0);
        chk({tag, "_halt"},  halted, 0);
        chk({tag, "_ipc"},   bus.instr_pc, 0);
    endtask

    task automatic load(input logic [12:0] a, input logic [31:0] d);
        bus.ld_req  = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        gold[a]     = d;
        settle;
        chk("ld_gnt",   bus.ld_gnt, 1);
        chk("ld_we",    {bus.mem_en, bus.mem_we}, 2'b11);
        chk("ld_addr",  bus.mem_addr, a);
        chk("ld_wdata", bus.mem_wdata, d);
        adv;
        bus.ld_req = 1'b0;
    endtask

    // Model state for the randomized phase.
    logic [12:0] exp_next;
    logic [12:0] rpc;
    logic [12:0] prev_ipc;
    logic [31:0] prev_instr;
    logic        prev_ld, prev_hold, st, ldq, rd;
    int          ncyc;

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]  = 32'h5000_0000 | i;
            gold[i] = 32'h5000_0000 | i;
        end
        bus.ld_req = 0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;

        // 1: reset, load, start, streaming
        settle;
        chk_reset("rst");
        #1 rst_n = 1'b1;
        adv;
        for (int i = 0; i < 4; i++) load(13'(i), 32'h1000_0000 + i);
        start = 1'b1;
        settle;
        chk("idle_en", bus.mem_en, 0);
        adv; start = 1'b0;
        settle;
        chk("c1_valid", bus.instr_valid, 0);
        chk("c1_rd", {bus.mem_en, bus.mem_we, 13'(bus.mem_addr)}, {2'b10, 13'd0});
        adv; settle;
        chk("c2_valid", bus.instr_valid, 1);
        chk("c2_ipc", bus.instr_pc, 0);
        chk("c2_instr", bus.instr, 32'h1000_0000);
        adv; settle;
        chk("c3_ipc", bus.instr_pc, 1);
        adv;

        // 2: stall for 3 cycles at instr_pc 2
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("st_ipc", bus.instr_pc, 2);
            chk("st_instr", bus.instr, 32'h1000_0002);
            chk("st_valid", bus.instr_valid, 1);
            chk("st_en", bus.mem_en, 0);
            adv;
        end
        bus.stall = 1'b0;
        settle;
        chk("rel_addr", bus.mem_addr, 3);
        adv; settle;
        chk("rel_ipc", bus.instr_pc, 3);
        chk("rel_instr", bus.instr, 32'h1000_0003);
        adv; adv;

        // 3: redirect to 100 while instr_pc 5 is presented
        bus.redirect = 1'b1; bus.redirect_pc = 13'd100;
        settle;
        chk("rd_ipc5", bus.instr_pc, 5);
        chk("rd_drop", bus.instr_valid, 0);
        chk("rd_addr", {bus.mem_en, bus.mem_we, 13'(bus.mem_addr)}, {2'b10, 13'd100});
        adv; bus.redirect = 1'b0;
        settle;
        chk("rd_ipc100", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd100});
        chk("rd_instr100", bus.instr, 32'h5000_0064);
        adv; settle;
        chk("rd_ipc101", bus.instr_pc, 101);

        // 4: loader steals the port with pc at 7
        adv;
        bus.redirect = 1'b1; bus.redirect_pc = 13'd6;
        adv; bus.redirect = 1'b0;
        bus.ld_req = 1'b1; bus.ld_addr = 13'd200; bus.ld_data = 32'hDEAD_0001;
        gold[200] = 32'hDEAD_0001;
        settle;
        chk("ldf_ipc6", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd6});
        chk("ldf_wr", {bus.ld_gnt, bus.mem_en, bus.mem_we, 13'(bus.mem_addr)}, {3'b111, 13'd200});
        adv; bus.ld_req = 1'b0;
        settle;
        chk("ldf_gap", bus.instr_valid, 0);
        chk("ldf_resume", {bus.mem_en, bus.mem_we, 13'(bus.mem_addr)}, {2'b10, 13'd7});
        adv; settle;
        chk("ldf_ipc7", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd7});
        chk("ldf_instr7", bus.instr, 32'h5000_0007);
        adv;

        // 5: halt word at address 4
        load(13'd4, HALT);
        bus.redirect = 1'b1; bus.redirect_pc = 13'd3;
        settle;
        chk("h_addr3", bus.mem_addr, 3);
        adv; bus.redirect = 1'b0;
        settle;
        chk("h_ipc3", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd3});
        adv; settle;
        chk("h_ipc4", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd4});
        chk("h_word", bus.instr, HALT);
        chk("h_noread", bus.mem_en, 0);
        adv;
        for (int i = 0; i < 2; i++) begin
            settle;
            chk("h_halted", halted, 1);
            chk("h_idle", {bus.instr_valid, bus.mem_en}, 2'b00);
            adv;
        end
        start = 1'b1;
        adv; start = 1'b0;
        settle;
        chk("h_restart", {halted, bus.mem_en, 13'(bus.mem_addr)}, {2'b01, 13'd0});
        adv; settle;
        chk("h_ipc0", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd0});
        adv;

        // 6: wrap at the top of the address space, then reset mid-stall
        bus.redirect = 1'b1; bus.redirect_pc = 13'd8191;
        settle;
        chk("w_addr", bus.mem_addr, 8191);
        adv; bus.redirect = 1'b0;
        settle;
        chk("w_ipc8191", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd8191});
        chk("w_instr", bus.instr, 32'h5000_1FFF);
        chk("w_next", bus.mem_addr, 0);
        adv; settle;
        chk("w_ipc0", {bus.instr_valid, 13'(bus.instr_pc)}, {1'b1, 13'd0});
        bus.stall = 1'b1;
        adv; adv;
        rst_n = 1'b0;
        #1;
        chk_reset("mrst");
        rst_n = 1'b1;
        bus.stall = 1'b0;
        adv;

        // Randomized phase against a stream-level model.
        load(13'd4, 32'h0BAD_C0DE);
        start = 1'b1;
        adv; start = 1'b0;
        exp_next = 13'd0; ncyc = 1; prev_ld = 0; prev_hold = 0;
        prev_ipc = '0; prev_instr = '0;
        for (int c = 0; c < 500; c++) begin
            st  = ($urandom % 3) == 0;
            ldq = ($urandom % 6) == 0;
            rd  = ($urandom % 8) == 0;
            rpc = (($urandom % 4) == 0) ? 13'(8190 + ($urandom % 2)) : 13'($urandom % 64);
            bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
            bus.ld_req = ldq;
            bus.ld_addr = 13'(6000 + ($urandom % 64));
            bus.ld_data = $urandom & 32'h7FFF_FFFF;
            if (ldq) gold[bus.ld_addr] = bus.ld_data;
            settle;
            chk("r_gnt", bus.ld_gnt, ldq);
            if (ldq) begin
                chk("r_wr", {bus.mem_en, bus.mem_we, 13'(bus.mem_addr)}, {2'b11, bus.ld_addr});
                chk("r_wdata", bus.mem_wdata, bus.ld_data);
            end else if (rd) begin
                chk("r_rdaddr", {bus.mem_en, bus.mem_we, 13'(bus.mem_addr)}, {2'b10, rpc});
            end
            if (rd) chk("r_drop", bus.instr_valid, 0);
            else if (ncyc >= 2 && !prev_ld) chk("r_live", bus.instr_valid, 1);
            if (prev_hold) begin
                chk("r_hold_pc", bus.instr_pc, prev_ipc);
                chk("r_hold_instr", bus.instr, prev_instr);
            end
            if (!ldq && !rd && bus.instr_valid && st) chk("r_stall_noread", bus.mem_en, 0);
            if (bus.instr_valid && !st) begin
                chk("r_order", bus.instr_pc, exp_next);
                chk("r_data", bus.instr, gold[exp_next]);
                exp_next = exp_next + 13'd1;
            end
            if (rd) exp_next = rpc;
            prev_ld    = ldq;
            prev_hold  = bus.instr_valid && st;
            prev_ipc   = bus.instr_pc;
            prev_instr = bus.instr;
            ncyc++;
            adv;
        end
        bus.ld_req = 0; bus.stall = 0; bus.redirect = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
